// File: rtl/fib_arbiter.sv
// fib_arbiter: round-robin arbiter sharing one Fibonacci core among four requesters.
// Optional watchdog abort is compiled in when FIB_ARB_TIMEOUT_EN is defined.
`default_nettype none

module fib_arbiter #(
   parameter int F_W     = 16,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [3:0]     req,
   input  logic [19:0]    i_bus,
   input  logic           core_ready,
   input  logic           core_done_tick,
   input  logic [F_W-1:0] core_f,
   output logic           core_start,
   output logic [4:0]     core_i,
   output logic [3:0]     done,
   output logic [F_W-1:0] f,
   output logic [1:0]     owner,
   output logic           busy,
   output logic           err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e         state_q, state_d;
   logic [1:0]     owner_q, owner_d;
   logic [1:0]     last_q, last_d;
   logic [4:0]     coreI_q, coreI_d;
   logic [F_W-1:0] f_q, f_d;

   logic           grantValid;
   logic [1:0]     grantIdx;
   logic [4:0]     grantOp;

`ifdef FIB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
`else
   // TIMEOUT only matters for the watchdog build.
   logic unusedTimeout;
   assign unusedTimeout = (TIMEOUT > 0);
`endif

   // Search starts just after the last served requester, so it ends up lowest priority.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = last_q;
      for (int k = 1; k <= 4; k++) begin
         if (!grantValid && req[last_q + 2'(k)]) begin
            grantValid = 1'b1;
            grantIdx   = last_q + 2'(k);
         end
      end
   end

   always_comb begin
      case (grantIdx)
         2'd0:    grantOp = i_bus[4:0];
         2'd1:    grantOp = i_bus[9:5];
         2'd2:    grantOp = i_bus[14:10];
         default: grantOp = i_bus[19:15];
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         last_q  <= 2'd3;
         coreI_q <= 5'd0;
         f_q     <= '0;
`ifdef FIB_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         coreI_q <= coreI_d;
         f_q     <= f_d;
`ifdef FIB_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      coreI_d = coreI_q;
      f_d     = f_q;
`ifdef FIB_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (core_ready && grantValid) begin
               owner_d = grantIdx;
               coreI_d = grantOp;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef FIB_ARB_TIMEOUT_EN
            cnt_d   = '0;
            tmo_d   = 1'b0;
`endif
         end
         WAIT: begin
            if (core_done_tick) begin
               f_d     = core_f;
               state_d = DONE;
            end
`ifdef FIB_ARB_TIMEOUT_EN
            // Abort leaves f untouched; the requester still gets its done pulse.
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               tmo_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DONE: begin
            last_d  = owner_q;
            state_d = IDLE;
`ifdef FIB_ARB_TIMEOUT_EN
            tmo_d   = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign core_start = (state_q == ISSUE);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE) ? (4'b0001 << owner_q) : 4'b0000;
   assign core_i     = coreI_q;
   assign f          = f_q;
   assign owner      = owner_q;
`ifdef FIB_ARB_TIMEOUT_EN
   assign err        = (state_q == DONE) && tmo_q;
`else
   assign err        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter: directed bench for fib_arbiter with a behavioural Fibonacci core
// and requesters that drop their request on done. Watchdog case follows FIB_ARB_TIMEOUT_EN.
module tb_fib_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [19:0] i_bus;
   logic        core_ready;
   logic        core_done_tick;
   logic [15:0] core_f;
   logic        core_start;
   logic [4:0]  core_i;
   logic [3:0]  done;
   logic [15:0] f;
   logic [1:0]  owner;
   logic        busy;
   logic        err;

   int checks   = 0;
   int failures = 0;

   logic [3:0]  doneQ[$];
   logic [15:0] fQ[$];
   logic        errQ[$];
   logic [4:0]  startOps[$];

   int          coreDelay  = 3;
   bit          coreHang   = 1'b0;
   int          coreCnt    = 0;
   logic [4:0]  coreOp     = 5'd0;
   bit          injectTick = 1'b0;
   bit          autoDrop   = 1'b1;

   localparam logic [19:0] OPS = {5'd20, 5'd3, 5'd2, 5'd1};

   fib_arbiter #(.F_W(16), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .req(req), .i_bus(i_bus),
      .core_ready(core_ready), .core_done_tick(core_done_tick), .core_f(core_f),
      .core_start(core_start), .core_i(core_i), .done(done), .f(f),
      .owner(owner), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] fibModel(input logic [4:0] n);
      logic [15:0] a = 16'd0;
      logic [15:0] b = 16'd1;
      logic [15:0] t;
      for (int i = 0; i < int'(n); i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Monitor, requester drop-on-done, and the core model all run on the falling edge.
   always @(negedge clk) begin
      if (done != 4'b0000) begin
         doneQ.push_back(done);
         fQ.push_back(f);
         errQ.push_back(err);
         if (autoDrop) req = req & ~done;
      end
      if (core_start) startOps.push_back(core_i);
      core_done_tick = 1'b0;
      if (coreCnt > 0) begin
         coreCnt--;
         if (coreCnt == 0) begin
            core_done_tick = 1'b1;
            core_f         = fibModel(coreOp);
         end
      end
      if (injectTick) begin
         core_done_tick = 1'b1;
         injectTick     = 1'b0;
      end
      if (core_start && !coreHang) begin
         coreOp  = core_i;
         coreCnt = coreDelay;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [19:0] bus);
      @(posedge clk);
      #1;
      req   = r;
      i_bus = bus;
   endtask

   task automatic flushQueues();
      doneQ.delete();
      fQ.delete();
      errQ.delete();
      startOps.delete();
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      req   = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      flushQueues();
   endtask

   task automatic waitDones(input int n, input int budget);
      int cyc = 0;
      while (doneQ.size() < n && cyc < budget) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      checkOutput($sformatf("doneCount>=%0d", n), 32'(doneQ.size() >= n), 32'd1);
   endtask

   task automatic waitIdle(input int budget);
      int cyc = 0;
      repeat (2) @(negedge clk);
      #1;
      while (busy && cyc < budget) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      checkOutput("idleReached", 32'(busy), 32'd0);
   endtask

   task automatic waitStart(input int budget);
      int cyc = 0;
      do begin
         @(negedge clk);
         #1;
         cyc++;
      end while (!core_start && cyc < budget);
      checkOutput("startSeen", 32'(core_start), 32'd1);
   endtask

   initial begin
      logic [3:0]  expDone[4];
      logic [15:0] expF[4];
      bit          sawStart, sawBusy, sawDone, sawErr;
      int          lat;

      reset = 1'b0; req = 4'b0000; i_bus = 20'd0;
      core_ready = 1'b1; core_done_tick = 1'b0; core_f = 16'd0;

      // Outputs while reset is held
      #2;
      checkOutput("rstBusy",  32'(busy), 32'd0);
      checkOutput("rstStart", 32'(core_start), 32'd0);
      checkOutput("rstDone",  32'(done), 32'd0);
      checkOutput("rstF",     32'(f), 32'd0);
      checkOutput("rstOwner", 32'(owner), 32'd0);
      checkOutput("rstCoreI", 32'(core_i), 32'd0);
      checkOutput("rstErr",   32'(err), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Single requester 2, operand 10 -> F(10)=55
      applyStimulus(4'b0100, {5'd0, 5'd10, 5'd0, 5'd0});
      waitDones(1, 50);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("r2StartCount", 32'(startOps.size()), 32'd1);
      checkOutput("r2CoreI",      32'(startOps[0]), 32'd10);
      checkOutput("r2DoneCount",  32'(doneQ.size()), 32'd1);
      checkOutput("r2DoneVec",    32'(doneQ[0]), 32'b0100);
      checkOutput("r2F",          32'(fQ[0]), 32'h0037);
      checkOutput("r2Err",        32'(errQ[0]), 32'd0);
      checkOutput("r2OwnerHold",  32'(owner), 32'd2);
      checkOutput("r2FHold",      32'(f), 32'h0037);

      // All four after reset: order 0,1,2,3
      applyReset();
      applyStimulus(4'b1111, OPS);
      waitDones(4, 200);
      expDone = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      expF    = '{16'h0001, 16'h0001, 16'h0002, 16'h1A6D};
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("allDone%0d", i), 32'(doneQ[i]), 32'(expDone[i]));
         checkOutput($sformatf("allF%0d", i),    32'(fQ[i]),    32'(expF[i]));
      end
      waitIdle(50);

      // last=1, then 3 must win over 0
      flushQueues();
      applyStimulus(4'b0010, OPS);
      waitDones(1, 50);
      waitIdle(50);
      applyStimulus(4'b1001, OPS);
      waitDones(3, 100);
      checkOutput("rrFirst",  32'(doneQ[1]), 32'b1000);
      checkOutput("rrSecond", 32'(doneQ[2]), 32'b0001);
      checkOutput("rrFirstF", 32'(fQ[1]), 32'h1A6D);
      checkOutput("rrSecondF", 32'(fQ[2]), 32'h0001);
      waitIdle(50);

      // Requesters that stay high re-queue at lowest priority (last=0 here)
      flushQueues();
      autoDrop = 1'b0;
      applyStimulus(4'b0011, OPS);
      waitDones(3, 200);
      applyStimulus(4'b0000, OPS);
      autoDrop = 1'b1;
      waitIdle(50);
      checkOutput("holdDone0", 32'(doneQ[0]), 32'b0010);
      checkOutput("holdDone1", 32'(doneQ[1]), 32'b0001);
      checkOutput("holdDone2", 32'(doneQ[2]), 32'b0010);

      // core_ready low blocks grants; start shows on the second falling edge after raising it
      flushQueues();
      @(posedge clk);
      #1;
      core_ready = 1'b0;
      req        = 4'b0001;
      sawStart   = 1'b0;
      sawBusy    = 1'b0;
      repeat (10) begin
         @(negedge clk);
         #1;
         if (core_start) sawStart = 1'b1;
         if (busy) sawBusy = 1'b1;
      end
      checkOutput("notReadyStart", 32'(sawStart), 32'd0);
      checkOutput("notReadyBusy",  32'(sawBusy), 32'd0);
      @(posedge clk);
      #1;
      core_ready = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         #1;
         lat++;
      end while (!core_start && lat < 10);
      checkOutput("readyLatency", 32'(lat), 32'd2);
      waitDones(1, 50);
      checkOutput("readyDone", 32'(doneQ[0]), 32'b0001);
      checkOutput("readyF",    32'(fQ[0]), 32'h0001);
      waitIdle(50);

      // Reset in WAIT aborts the job; the late tick is ignored
      flushQueues();
      coreDelay = 20;
      applyStimulus(4'b0001, OPS);
      waitStart(20);
      @(negedge clk);
      #1;
      checkOutput("abortInWait", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("abortBusy",  32'(busy), 32'd0);
      checkOutput("abortStart", 32'(core_start), 32'd0);
      checkOutput("abortDone",  32'(done), 32'd0);
      checkOutput("abortF",     32'(f), 32'd0);
      checkOutput("abortOwner", 32'(owner), 32'd0);
      checkOutput("abortCoreI", 32'(core_i), 32'd0);
      req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      reset      = 1'b1;
      injectTick = 1'b1;
      sawBusy    = 1'b0;
      repeat (30) begin
         @(negedge clk);
         #1;
         if (busy) sawBusy = 1'b1;
      end
      checkOutput("abortNoDone",  32'(doneQ.size()), 32'd0);
      checkOutput("abortStayIdle", 32'(sawBusy), 32'd0);
      checkOutput("abortFAfter",  32'(f), 32'd0);
      coreDelay = 3;

`ifdef FIB_ARB_TIMEOUT_EN
      // Watchdog: DONE is entered 64 edges after WAIT entry, i.e. 65 falling edges after ISSUE
      flushQueues();
      applyStimulus(4'b0100, {5'd0, 5'd10, 5'd0, 5'd0});
      waitDones(1, 50);
      waitIdle(50);
      coreHang = 1'b1;
      applyStimulus(4'b0100, {5'd0, 5'd10, 5'd0, 5'd0});
      waitStart(20);
      lat = 0;
      do begin
         @(negedge clk);
         #1;
         lat++;
      end while (done == 4'b0000 && lat < 200);
      checkOutput("tmoLatency", 32'(lat), 32'd65);
      checkOutput("tmoDone",    32'(done), 32'b0100);
      checkOutput("tmoErr",     32'(err), 32'd1);
      checkOutput("tmoFKept",   32'(f), 32'h0037);
      @(negedge clk);
      #1;
      checkOutput("tmoErrPulse", 32'(err), 32'd0);
      coreHang = 1'b0;
      waitIdle(50);
`else
      // Without the watchdog a silent core keeps the arbiter in WAIT
      flushQueues();
      coreHang = 1'b1;
      applyStimulus(4'b0100, {5'd0, 5'd10, 5'd0, 5'd0});
      sawDone = 1'b0;
      sawErr  = 1'b0;
      sawBusy = 1'b1;
      repeat (100) begin
         @(negedge clk);
         #1;
         if (done != 4'b0000) sawDone = 1'b1;
         if (err) sawErr = 1'b1;
      end
      checkOutput("hangNoDone", 32'(sawDone), 32'd0);
      checkOutput("hangNoErr",  32'(sawErr), 32'd0);
      checkOutput("hangBusy",   32'(busy), 32'(sawBusy));
      applyReset();
      coreHang = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: got no finish, expected finish before 200000ns");
      $fatal(1);
   end

endmodule
